bpf16_decim_framer: RTL



---
 rtl/bpf16_pkg.sv | 17 +
 rtl/bpf16_decim_framer_if.sv | 13 +
 rtl/bpf16_decim_framer_fifo2.sv | 61 ++++++
 rtl/bpf16_decim_framer.sv | 87 ++++++++
 4 files changed

// File: rtl/bpf16_pkg.sv
// rtl/bpf16_pkg.sv - shared sample/beat types for the BPF16 filter chain
package bpf16_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t data;
    logic    last;
  } beat_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bpf16_decim_framer_if.sv
// rtl/bpf16_decim_framer_if.sv - AXI-Stream style handshake bundle
interface bpf16_decim_framer_if #(
  parameter int DATA_W = 16
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  // Sample input side carries no frame marker.
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/bpf16_decim_framer_fifo2.sv
// rtl/bpf16_decim_framer_fifo2.sv - generic 2-entry stream buffer, payload type T
module axis_fifo2 #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  T           head_q, head_d;
  T           tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push, pop;

  // Ready depends only on occupancy (and reset), never on out_ready_i.
  assign in_ready_o  = ~rst & (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data_i;
        else               tail_d = in_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Only reachable with one entry: the newcomer replaces the head.
        head_d = in_data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bpf16_decim_framer.sv
// rtl/bpf16_decim_framer.sv - keep 1-in-DECIM samples, frame them with tlast, count frames
module bpf16_decim_framer
  import bpf16_pkg::*;
#(
  parameter int DATA_W    = SAMPLE_W,
  parameter int DECIM     = 4,
  parameter int FRAME_LEN = 64,
  parameter int FCNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  bpf16_decim_framer_if.slave   s_axis,
  bpf16_decim_framer_if.master  m_axis,
  input  logic                  sync,
  output logic [FCNT_W-1:0]     frame_cnt
);

  localparam int PH_W  = cnt_w(DECIM);
  localparam int IDX_W = cnt_w(FRAME_LEN);

  if (DECIM < 1) begin : g_bad_decim
    $fatal(1, "bpf16_decim_framer: DECIM must be >= 1");
  end
  if (FRAME_LEN < 1) begin : g_bad_frame
    $fatal(1, "bpf16_decim_framer: FRAME_LEN must be >= 1");
  end
  if (DATA_W != SAMPLE_W) begin : g_bad_width
    $fatal(1, "bpf16_decim_framer: DATA_W must equal SAMPLE_W");
  end

  logic [PH_W-1:0]   phase_q, phase_d, phase_eff;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_eff;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              in_ready, accept, keep, is_last;
  logic              out_valid;
  beat_t             in_beat, out_beat;

  // sync forces the beat of this same cycle to phase 0 / index 0.
  always_comb begin
    phase_eff = sync ? '0 : phase_q;
    idx_eff   = sync ? '0 : idx_q;
    accept    = s_axis.tvalid & in_ready;
    keep      = accept & (phase_eff == '0);
    is_last   = (idx_eff == IDX_W'(FRAME_LEN - 1));
    phase_d   = phase_eff;
    idx_d     = idx_eff;
    if (accept) phase_d = (phase_eff == PH_W'(DECIM - 1)) ? '0 : phase_eff + 1'b1;
    if (keep)   idx_d   = is_last ? '0 : idx_eff + 1'b1;
  end

  always_comb begin
    in_beat.data = sample_t'(s_axis.tdata);
    in_beat.last = is_last;
    fcnt_d       = fcnt_q;
    if (out_valid && m_axis.tready && out_beat.last) fcnt_d = fcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      idx_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
    end
  end

  axis_fifo2 #(.T(beat_t)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (keep),
    .in_ready_o  (in_ready),
    .in_data_i   (in_beat),
    .out_valid_o (out_valid),
    .out_ready_i (m_axis.tready),
    .out_data_o  (out_beat)
  );

  assign s_axis.tready = in_ready;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_beat.data;
  assign m_axis.tlast  = out_beat.last;
  assign frame_cnt     = fcnt_q;

endmodule
